dorodon_input_ctrl: RTL

DORODON_INPUT_CTRL -- requirements
Module: dorodon_input_ctrl

---
 rtl/dorodon_input_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dorodon_input_ctrl.sv
// rtl/dorodon_input_ctrl.sv - Dorodon input controller: PS/2 key latches, joystick merge, coin pulse FSMs
// Keys and pads merge into active-low per-player buttons; coin requests become frame-timed pulses.
module dorodon_input_ctrl #(
  parameter int COIN_FRAMES = 4,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        no_rotate,
  input  logic        vblank,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_coin_s,
  output logic        key_evt
);

  localparam int MAXF = (COIN_FRAMES > LOCK_FRAMES) ? COIN_FRAMES : LOCK_FRAMES;
  localparam int CW = $clog2(MAXF + 1);
  localparam logic [CW-1:0] COIN_CNT = CW'(COIN_FRAMES);
  localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_FRAMES);

  localparam int K_UP1    = 0;
  localparam int K_DOWN1  = 1;
  localparam int K_LEFT1  = 2;
  localparam int K_RIGHT1 = 3;
  localparam int K_FIRE1  = 4;
  localparam int K_BOMB1  = 5;
  localparam int K_START1 = 6;
  localparam int K_START2 = 7;
  localparam int K_COIN1  = 8;
  localparam int K_COIN2  = 9;
  localparam int K_UP2    = 10;
  localparam int K_DOWN2  = 11;
  localparam int K_LEFT2  = 12;
  localparam int K_RIGHT2 = 13;
  localparam int K_FIRE2  = 14;
  localparam int K_BOMB2  = 15;

  typedef enum logic [1:0] {IDLE, PULSE, LOCK} coin_state_t;

  logic        tog_q;
  logic        evt;
  logic [15:0] keys;
  logic [15:0] key_hit;
  logic [1:0]  up_v, down_v, left_v, right_v, fire_v, bomb_v, sel_v, req_v;
  logic [1:0]  req_q, req_d, req_edge;
  logic        vb_q, tick;
  logic        unused_joy;

  assign unused_joy = ^joy[15:9];
  assign evt        = ps2_key[10] ^ tog_q;
  assign req_edge   = req_q & ~req_d;
  assign tick       = vblank & ~vb_q;

  // Arrow keys match with either extended-bit value; the rest must be non-extended.
  always_comb begin
    key_hit = '0;
    case (ps2_key[7:0])
      8'h75:   key_hit[K_UP1]    = 1'b1;
      8'h72:   key_hit[K_DOWN1]  = 1'b1;
      8'h6B:   key_hit[K_LEFT1]  = 1'b1;
      8'h74:   key_hit[K_RIGHT1] = 1'b1;
      default: ;
    endcase
    if (!ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h14:        key_hit[K_FIRE1]  = 1'b1;
        8'h29:        key_hit[K_BOMB1]  = 1'b1;
        8'h05, 8'h16: key_hit[K_START1] = 1'b1;
        8'h06, 8'h1E: key_hit[K_START2] = 1'b1;
        8'h2E:        key_hit[K_COIN1]  = 1'b1;
        8'h36:        key_hit[K_COIN2]  = 1'b1;
        8'h2D:        key_hit[K_UP2]    = 1'b1;
        8'h2B:        key_hit[K_DOWN2]  = 1'b1;
        8'h23:        key_hit[K_LEFT2]  = 1'b1;
        8'h34:        key_hit[K_RIGHT2] = 1'b1;
        8'h1C:        key_hit[K_FIRE2]  = 1'b1;
        8'h1B:        key_hit[K_BOMB2]  = 1'b1;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (!reset_n) begin
      keys    <= '0;
      key_evt <= 1'b0;
    end else begin
      key_evt <= evt;
      if (evt) keys <= (keys & ~key_hit) | (key_hit & {16{ps2_key[9]}});
    end
  end

  always_comb begin
    if (no_rotate) begin
      up_v    = {keys[K_LEFT2],  keys[K_LEFT1]}  | {2{joy[1]}};
      down_v  = {keys[K_RIGHT2], keys[K_RIGHT1]} | {2{joy[0]}};
      left_v  = {keys[K_DOWN2],  keys[K_DOWN1]}  | {2{joy[2]}};
      right_v = {keys[K_UP2],    keys[K_UP1]}    | {2{joy[3]}};
    end else begin
      up_v    = {keys[K_UP2],    keys[K_UP1]}    | {2{joy[3]}};
      down_v  = {keys[K_DOWN2],  keys[K_DOWN1]}  | {2{joy[2]}};
      left_v  = {keys[K_LEFT2],  keys[K_LEFT1]}  | {2{joy[1]}};
      right_v = {keys[K_RIGHT2], keys[K_RIGHT1]} | {2{joy[0]}};
    end
    fire_v = {keys[K_FIRE2], keys[K_FIRE1]} | {2{joy[4]}};
    bomb_v = {keys[K_BOMB2], keys[K_BOMB1]} | {2{joy[5]}};
    sel_v  = {keys[K_START2] | joy[7], keys[K_START1] | joy[6]};
    req_v  = {keys[K_COIN2], keys[K_COIN1] | joy[8] | sel_v[0] | sel_v[1]};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      but_up_s     <= 2'b11;
      but_down_s   <= 2'b11;
      but_left_s   <= 2'b11;
      but_right_s  <= 2'b11;
      but_fire_s   <= 2'b11;
      but_bomb_s   <= 2'b11;
      but_select_s <= 2'b11;
    end else begin
      but_up_s     <= ~up_v;
      but_down_s   <= ~down_v;
      but_left_s   <= ~left_v;
      but_right_s  <= ~right_v;
      but_fire_s   <= ~fire_v;
      but_bomb_s   <= ~bomb_v;
      but_select_s <= ~sel_v;
    end
  end

  // Request history tracks live inputs through reset so a held coin cannot fire on release.
  always_ff @(posedge clk_sys) begin
    vb_q  <= vblank;
    req_q <= req_v;
    req_d <= reset_n ? req_q : req_v;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_coin
    coin_state_t    state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           coin_n;

    assign cnt_inc        = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    assign but_coin_s[ch] = coin_n;

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
        coin_n <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (req_edge[ch]) begin
              state  <= PULSE;
              cnt    <= '0;
              coin_n <= 1'b0;
            end
          end
          PULSE: begin
            if (tick) begin
              if (cnt_inc >= COIN_CNT) begin
                state  <= LOCK;
                cnt    <= '0;
                coin_n <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          LOCK: begin
            if (cnt >= LOCK_CNT && !req_q[ch]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (tick) begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state  <= IDLE;
            coin_n <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
